// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle for bcd_countdown_timer: load/start/stop in, BCD count and state flags out.
// W must equal 4*(MIN_DIGITS+2+NUM_FRAC) of the attached timer.
interface bcd_countdown_timer_if #(
    parameter int W = 24
);
    logic         load;
    logic [W-1:0] load_value;
    logic         start;
    logic         stop;
    logic [W-1:0] value;
    logic         running;
    logic         paused;
    logic         done;
    logic         expired;
    logic         blink;

    modport master (
        output load, load_value, start, stop,
        input  value, running, paused, done, expired, blink
    );

    modport slave (
        input  load, load_value, start, stop,
        output value, running, paused, done, expired, blink
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Parametrised BCD countdown timer (minutes : seconds . fraction) with prescaler, done/expired and blink.
// Optional AUTO_RELOAD_EN: reload the last loaded value instead of stopping at zero.
module bcd_countdown_timer #(
    parameter int MIN_DIGITS = 1,
    parameter int NUM_FRAC   = 3,
    parameter int TICK_DIV   = 1,
    parameter int RESET_SEC  = 10,
    parameter int BLINK_DIV  = 250
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_countdown_timer_if.slave  bus
);
    localparam int ND   = MIN_DIGITS + 2 + NUM_FRAC;
    localparam int W    = 4 * ND;
    localparam int TENS = NUM_FRAC + 1;
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [W-1:0] RESET_VAL = (W'(RESET_SEC / 10) << (4 * TENS))
                                       | (W'(RESET_SEC % 10) << (4 * NUM_FRAC));

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    // Seconds-tens rolls over at 5, every other digit at 9.
    function automatic logic [3:0] digit_max(input int idx);
        return (idx == TENS) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < ND; i++)
            if (r[4*i +: 4] > digit_max(i)) r[4*i +: 4] = digit_max(i);
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = digit_max(i);
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    state_t         state_q, state_next;
    logic [W-1:0]   value_q, value_next;
    logic [PW-1:0]  presc_q, presc_next;
    logic [BW-1:0]  bcnt_q, bcnt_next;
    logic           blink_q, blink_next;
    logic           expired_q, expired_next;
    logic           running_q, paused_q, done_q;
    logic [W-1:0]   load_clamped;
    logic [W-1:0]   dec_val;
`ifdef AUTO_RELOAD_EN
    logic [W-1:0]   shadow_q;
`endif

    assign load_clamped = clamp_bcd(bus.load_value);
    assign dec_val      = bcd_dec(value_q);

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_next   = state_q;
        value_next   = value_q;
        presc_next   = presc_q;
        bcnt_next    = bcnt_q;
        blink_next   = blink_q;
        expired_next = 1'b0;

        if (bus.load) begin
            value_next = load_clamped;
            state_next = IDLE;
            presc_next = '0;
            bcnt_next  = '0;
            blink_next = 1'b1;
        end else begin
            case (state_q)
                IDLE, PAUSE: begin
                    if (bus.start && !bus.stop) begin
                        if (value_q != '0) begin
                            state_next = RUN;
                        end else begin
                            state_next   = DONE;
                            expired_next = 1'b1;
                            bcnt_next    = '0;
                            blink_next   = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_next = PAUSE;
                    end else if (presc_q == PW'(TICK_DIV - 1)) begin
                        presc_next = '0;
                        if (dec_val != '0) begin
                            value_next = dec_val;
`ifdef AUTO_RELOAD_EN
                        end else if (shadow_q != '0) begin
                            value_next   = shadow_q;
                            expired_next = 1'b1;
`endif
                        end else begin
                            value_next   = '0;
                            state_next   = DONE;
                            expired_next = 1'b1;
                            bcnt_next    = '0;
                            blink_next   = 1'b1;
                        end
                    end else begin
                        presc_next = presc_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bcnt_q == BW'(BLINK_DIV - 1)) begin
                        bcnt_next  = '0;
                        blink_next = ~blink_q;
                    end else begin
                        bcnt_next = bcnt_q + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            value_q   <= RESET_VAL;
            presc_q   <= '0;
            bcnt_q    <= '0;
            blink_q   <= 1'b1;
            expired_q <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_next;
            value_q   <= value_next;
            presc_q   <= presc_next;
            bcnt_q    <= bcnt_next;
            blink_q   <= blink_next;
            expired_q <= expired_next;
            running_q <= (state_next == RUN);
            paused_q  <= (state_next == PAUSE);
            done_q    <= (state_next == DONE);
        end
    end

`ifdef AUTO_RELOAD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         shadow_q <= RESET_VAL;
        else if (bus.load) shadow_q <= load_clamped;
    end
`endif

    assign bus.value   = value_q;
    assign bus.running = running_q;
    assign bus.paused  = paused_q;
    assign bus.done    = done_q;
    assign bus.expired = expired_q;
    assign bus.blink   = blink_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: two instances (TICK_DIV 1 and 4) against a count-based model.
// Works with or without AUTO_RELOAD_EN defined.
module tb_bcd_countdown_timer;
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;

    logic clk;
    logic reset;

    bcd_countdown_timer_if #(.W(24)) if0 ();
    bcd_countdown_timer_if #(.W(24)) if1 ();

    bcd_countdown_timer #(.MIN_DIGITS(1), .NUM_FRAC(3), .TICK_DIV(1), .RESET_SEC(10), .BLINK_DIV(250))
        u0 (.clk(clk), .reset(reset), .bus(if0));
    bcd_countdown_timer #(.MIN_DIGITS(1), .NUM_FRAC(3), .TICK_DIV(4), .RESET_SEC(59), .BLINK_DIV(3))
        u1 (.clk(clk), .reset(reset), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the count is held as an integer number of millisecond-digit units.
    int      td[2] = '{1, 4};
    int      bd[2] = '{250, 3};
    int      rs[2] = '{10, 59};
    int      m_cnt[2];
    int      m_shadow[2];
    int      m_presc[2];
    int      m_bcnt[2];
    mstate_t m_st[2];
    bit      m_exp[2];
    bit      m_blink[2];

    logic [28:0] obs0, obs1;
    assign obs0 = {if0.value, if0.running, if0.paused, if0.done, if0.expired, if0.blink};
    assign obs1 = {if1.value, if1.running, if1.paused, if1.done, if1.expired, if1.blink};

    int k_done, nexp, blink_k[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bcd_to_count(input logic [23:0] v);
        int d[6];
        for (int i = 0; i < 6; i++) begin
            d[i] = int'(v[4*i +: 4]);
            if (d[i] > 9) d[i] = 9;
        end
        if (d[4] > 5) d[4] = 5;
        return (d[5] * 60 + d[4] * 10 + d[3]) * 1000 + d[2] * 100 + d[1] * 10 + d[0];
    endfunction

    function automatic logic [23:0] count_to_bcd(input int c);
        int fr, s, m;
        fr = c % 1000;
        s  = (c / 1000) % 60;
        m  = c / 60000;
        return {4'(m), 4'(s / 10), 4'(s % 10), 4'(fr / 100), 4'((fr / 10) % 10), 4'(fr % 10)};
    endfunction

    task automatic model_reset(input int i);
        m_cnt[i]    = rs[i] * 1000;
        m_shadow[i] = m_cnt[i];
        m_presc[i]  = 0;
        m_bcnt[i]   = 0;
        m_st[i]     = M_IDLE;
        m_exp[i]    = 1'b0;
        m_blink[i]  = 1'b1;
    endtask

    task automatic enter_done(input int i);
        m_st[i]    = M_DONE;
        m_exp[i]   = 1'b1;
        m_blink[i] = 1'b1;
        m_bcnt[i]  = 0;
    endtask

    task automatic model_step(input int i, input bit ld, input logic [23:0] lv, input bit st, input bit sp);
        m_exp[i] = 1'b0;
        if (ld) begin
            m_cnt[i]    = bcd_to_count(lv);
            m_shadow[i] = m_cnt[i];
            m_st[i]     = M_IDLE;
            m_presc[i]  = 0;
            m_bcnt[i]   = 0;
            m_blink[i]  = 1'b1;
        end else if (m_st[i] == M_DONE) begin
            if (m_bcnt[i] == bd[i] - 1) begin
                m_bcnt[i]  = 0;
                m_blink[i] = !m_blink[i];
            end else begin
                m_bcnt[i]++;
            end
        end else if (sp) begin
            if (m_st[i] == M_RUN) m_st[i] = M_PAUSE;
        end else if (st && m_st[i] != M_RUN) begin
            if (m_cnt[i] != 0) m_st[i] = M_RUN;
            else enter_done(i);
        end else if (m_st[i] == M_RUN) begin
            if (m_presc[i] == td[i] - 1) begin
                m_presc[i] = 0;
                if (m_cnt[i] > 1) begin
                    m_cnt[i]--;
                end else begin
`ifdef AUTO_RELOAD_EN
                    if (m_shadow[i] != 0) begin
                        m_cnt[i] = m_shadow[i];
                        m_exp[i] = 1'b1;
                    end else begin
                        m_cnt[i] = 0;
                        enter_done(i);
                    end
`else
                    m_cnt[i] = 0;
                    enter_done(i);
`endif
                end
            end else begin
                m_presc[i]++;
            end
        end
    endtask

    task automatic compare_all(input string ph);
        logic [28:0] o;
        for (int i = 0; i < 2; i++) begin
            o = (i == 0) ? obs0 : obs1;
            check($sformatf("%s u%0d.value", ph, i), 32'(o[28:5]), 32'(count_to_bcd(m_cnt[i])));
            check($sformatf("%s u%0d.running", ph, i), 32'(o[4]), 32'(m_st[i] == M_RUN));
            check($sformatf("%s u%0d.paused", ph, i), 32'(o[3]), 32'(m_st[i] == M_PAUSE));
            check($sformatf("%s u%0d.done", ph, i), 32'(o[2]), 32'(m_st[i] == M_DONE));
            check($sformatf("%s u%0d.expired", ph, i), 32'(o[1]), 32'(m_exp[i]));
            check($sformatf("%s u%0d.blink", ph, i), 32'(o[0]), 32'(m_blink[i]));
        end
    endtask

    task automatic drive(input bit ld, input logic [23:0] lv, input bit st, input bit sp);
        if0.load = ld; if0.load_value = lv; if0.start = st; if0.stop = sp;
        if1.load = ld; if1.load_value = lv; if1.start = st; if1.stop = sp;
    endtask

    // One clock: apply inputs, advance the model at the edge, compare on the falling edge.
    task automatic step(input bit ld = 1'b0, input logic [23:0] lv = 24'h0,
                        input bit st = 1'b0, input bit sp = 1'b0);
        drive(ld, lv, st, sp);
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i, ld, lv, st, sp);
        @(negedge clk);
        compare_all("step");
    endtask

    task automatic do_reset();
        drive(1'b0, 24'h0, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        for (int i = 0; i < 2; i++) model_reset(i);
        compare_all("rst");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 24'h0, 1'b0, 1'b0);
        @(negedge clk);
        do_reset();

        // Reset defaults straight from the parameters.
        check("rst u0 value", 32'(if0.value), 32'h010000);
        check("rst u1 value", 32'(if1.value), 32'h059000);
        check("rst u0 running", 32'(if0.running), 32'd0);
        check("rst u0 done", 32'(if0.done), 32'd0);
        check("rst u0 blink", 32'(if0.blink), 32'd1);

        // Full 10 s countdown at one tick per cycle.
        step(1'b0, 24'h0, 1'b1);
        k_done = -1;
        nexp   = 0;
        for (int k = 1; k <= 10010; k++) begin
            step();
            if (if0.expired) nexp++;
            if (if0.done && k_done < 0) k_done = k;
        end
`ifndef AUTO_RELOAD_EN
        check("full run done cycle", 32'(k_done), 32'd10000);
        check("full run value", 32'(if0.value), 32'h0);
        check("full run expired pulses", 32'(nexp), 32'd1);
`endif

        // Borrow across every digit.
        step(1'b1, 24'h100000);
        step(1'b0, 24'h0, 1'b1);
        step();
        check("full borrow", 32'(if0.value), 32'h059999);

        // Clamp on load.
        step(1'b1, 24'hA7FFFF);
        check("clamp value", 32'(if0.value), 32'h959999);
        check("clamp idle", 32'({if0.running, if0.paused, if0.done}), 32'd0);

        // Pause after two ticks, hold, resume.
        step(1'b1, 24'h000005);
        step(1'b0, 24'h0, 1'b1);
        step();
        step();
        step(1'b0, 24'h0, 1'b0, 1'b1);
        check("pause value", 32'(if0.value), 32'h000003);
        check("pause flag", 32'(if0.paused), 32'd1);
        for (int k = 0; k < 20; k++) step();
        check("pause hold", 32'(if0.value), 32'h000003);
        step(1'b0, 24'h0, 1'b1);
        step(); step(); step();
`ifndef AUTO_RELOAD_EN
        check("resume done", 32'(if0.done), 32'd1);
`endif

        // Stop and start together: stop wins.
        step(1'b1, 24'h000009);
        step(1'b0, 24'h0, 1'b1, 1'b1);
        check("stop beats start", 32'(if0.running), 32'd0);

        // Prescaled countdown on u1.
        step(1'b1, 24'h000003);
        step(1'b0, 24'h0, 1'b1);
        k_done = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (if1.done && k_done < 0) k_done = k;
        end
`ifndef AUTO_RELOAD_EN
        check("tick_div4 done latency", 32'(k_done), 32'd12);
`endif

        // load and start together: load wins, stays idle.
        step(1'b1, 24'h000042, 1'b1);
        check("load+start value", 32'(if0.value), 32'h000042);
        check("load+start idle", 32'(if1.running), 32'd0);

`ifdef AUTO_RELOAD_EN
        step(1'b1, 24'h000002);
        step(1'b0, 24'h0, 1'b1);
        for (int j = 1; j <= 8; j++) begin
            step();
            check("reload value", 32'(if0.value), (j % 2 == 1) ? 32'h1 : 32'h2);
            check("reload expired", 32'(if0.expired), 32'(j % 2 == 0));
            check("reload no done", 32'(if0.done), 32'd0);
        end
`else
        // Blink cadence after done rises, both BLINK_DIV values.
        step(1'b1, 24'h000001);
        step(1'b0, 24'h0, 1'b1);
        blink_k = '{-1, -1};
        for (int n = 0; n < 600; n++) begin
            step();
            if (if0.done) begin
                blink_k[0]++;
                check("blink u0", 32'(if0.blink), 32'((blink_k[0] / 250) % 2 == 0));
            end
            if (if1.done) begin
                blink_k[1]++;
                check("blink u1", 32'(if1.blink), 32'((blink_k[1] / 3) % 2 == 0));
            end
        end
`endif

        // Random traffic, with one asynchronous reset in the middle.
        for (int n = 0; n < 4000; n++) begin
            bit          r_ld, r_st, r_sp;
            logic [23:0] r_lv;
            if (n == 2000) do_reset();
            r_ld = ($urandom_range(0, 39) == 0);
            r_st = ($urandom_range(0, 7) == 0);
            r_sp = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0)
                r_lv = 24'($urandom);
            else
                r_lv = {16'h0, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
            step(r_ld, r_lv, r_st, r_sp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
